// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU data-memory request/response protocol.
package mem_bus_pkg;

  localparam int BE_W        = 4;
  localparam int DATA_W      = 32;
  localparam int WORD_ADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] addr;
    logic                   we;
    logic [BE_W-1:0]        be;
    logic [DATA_W-1:0]      wdata;
  } req_t;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port RAM with per-byte write enables; read-first, one-cycle read latency.
// Output word holds its value while en is low; contents are never reset.
module mem_resp_ram
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   wbe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Target end of the data-memory protocol: one request at a time, RAM access WAIT_STATES edges after accept.
// Response is held until resp_ready; req_ready is low outside IDLE.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WORD_ADDR_W-1:0] req_addr,
  input  logic                   req_we,
  input  logic [BE_W-1:0]        req_be,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err,
  output logic                   busy
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            state, state_nxt;
  req_t              cap;
  req_t              req_in;
  req_t              acc;
  logic [3:0]        cnt;
  logic              acc_err;
  logic              accept;
  logic              do_access;
  logic              rd_ok;
  logic              err_q;
  logic [DATA_W-1:0] ram_q;

  // With zero wait states the access uses the live request on the accept edge.
  always_comb begin
    req_in       = '0;
    req_in.addr  = req_addr;
    req_in.we    = req_we;
    req_in.be    = req_be;
    req_in.wdata = req_wdata;
    acc          = (state == IDLE) ? req_in : cap;
    acc_err      = (acc.addr >> ADDR_W) != '0;
    accept       = (state == IDLE) && req_valid;
    do_access    = (accept && (WS == 4'd0)) || ((state == WAIT) && (cnt == 4'd1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WS == 4'd0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cap   <= '0;
      cnt   <= '0;
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap <= req_in;
        cnt <= WS;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rd_ok <= !acc.we && !acc_err;
        err_q <= acc_err;
      end else if ((state == RESP) && resp_ready) begin
        rd_ok <= 1'b0;
        err_q <= 1'b0;
      end
    end
  end

  mem_resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (do_access && !acc_err),
    .wbe   (acc.we ? acc.be : '0),
    .addr  (acc.addr[ADDR_W-1:0]),
    .wdata (acc.wdata),
    .rdata (ram_q)
  );

  // RAM output word is only meaningful for an in-range read.
  assign resp_rdata = rd_ok ? ram_q : '0;
  assign resp_err   = err_q;
  assign resp_valid = (state == RESP);
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

endmodule
